// File: rtl/ota_cal_ctrl.sv
// SAR trim calibration controller for CH OTA channels with manual trim load and abort.
// Define OTA_CAL_CMP_SYNC_EN to sample cmp_in through a 2-flop synchronizer.
module ota_cal_ctrl #(
    parameter int CH     = 2,
    parameter int W      = 6,
    parameter int SETTLE = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    ch_sel,
    input  logic          load_valid,
    input  logic [W-1:0]  load_data,
    input  logic          cmp_in,
    output logic [CH*W-1:0] trim_out,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam logic [W-1:0] MID = W'(1) << (W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nx_s;
    logic [W-1:0]    trim_r [CH];
    logic [W-1:0]    saved_r;
    logic [1:0]      ch_r;
    logic [BW-1:0]   bit_r;
    logic [3:0]      cnt_r;
    logic            busy_r;
    logic            done_r;
    logic            err_r;
    logic            cmp_s;
    logic            ch_ok_s;
    logic            start_ok_s;
    logic            load_ok_s;
    logic            err_s;
    logic [W-1:0]    trial_s;
    logic [W-1:0]    mask_s;
    logic [W-1:0]    next_code_s;

`ifdef OTA_CAL_CMP_SYNC_EN
    logic [1:0] sync_r;

    // Two-stage synchronizer for the asynchronous comparator output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], cmp_in};
        end
    end

    assign cmp_s = sync_r[1];
`else
    assign cmp_s = cmp_in;
`endif

    assign ch_ok_s = ({30'd0, ch_sel} < 32'(CH));
    assign trial_s = trim_r[ch_r];
    assign mask_s  = W'(1) << bit_r;

    // SAR step: drop the trial bit if the output is above reference, then arm the next bit
    always_comb begin
        next_code_s = trial_s;
        if (cmp_s) begin
            next_code_s = trial_s & ~mask_s;
        end else begin
            next_code_s = trial_s;
        end
        if (bit_r != '0) begin
            next_code_s = next_code_s | (mask_s >> 1);
        end else begin
            next_code_s = next_code_s;
        end
    end

    // Next-state and command decode; ena low freezes the whole FSM
    always_comb begin
        state_nx_s = state_r;
        start_ok_s = 1'b0;
        load_ok_s  = 1'b0;
        err_s      = 1'b0;
        if (ena) begin
            case (state_r)
                S_IDLE: begin
                    if (start || load_valid) begin
                        if (!ch_ok_s) begin
                            err_s = 1'b1;
                        end else if (start) begin
                            start_ok_s = 1'b1;
                            state_nx_s = S_SETTLE;
                        end else begin
                            load_ok_s = 1'b1;
                        end
                    end else begin
                        state_nx_s = S_IDLE;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        state_nx_s = S_IDLE;
                    end else if (cnt_r == 4'd0) begin
                        state_nx_s = S_SAMPLE;
                    end else begin
                        state_nx_s = S_SETTLE;
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        state_nx_s = S_IDLE;
                    end else if (bit_r == '0) begin
                        state_nx_s = S_FINISH;
                    end else begin
                        state_nx_s = S_SETTLE;
                    end
                end
                S_FINISH: state_nx_s = S_IDLE;
                default:  state_nx_s = S_IDLE;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // State register and registered status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != S_IDLE);
            done_r  <= (state_nx_s == S_FINISH) && (state_r != S_FINISH);
            err_r   <= err_s;
        end
    end

    // Trim storage; the selected channel register itself carries the live trial code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                trim_r[c] <= MID;
            end
            saved_r <= MID;
            ch_r    <= 2'd0;
            bit_r   <= '0;
            cnt_r   <= 4'd0;
        end else if (ena) begin
            case (state_r)
                S_IDLE: begin
                    if (start_ok_s) begin
                        saved_r        <= trim_r[ch_sel];
                        trim_r[ch_sel] <= MID;
                        ch_r           <= ch_sel;
                        bit_r          <= BW'(W - 1);
                        cnt_r          <= 4'(SETTLE - 1);
                    end else if (load_ok_s) begin
                        trim_r[ch_sel] <= load_data;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        trim_r[ch_r] <= saved_r;
                    end else if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        trim_r[ch_r] <= saved_r;
                    end else begin
                        trim_r[ch_r] <= next_code_s;
                        cnt_r        <= 4'(SETTLE - 1);
                        if (bit_r != '0) begin
                            bit_r <= bit_r - BW'(1);
                        end
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_trim
        assign trim_out[c*W +: W] = trim_r[c];
    end

    assign busy = busy_r;
    assign done = done_r;
    assign err  = err_r;

endmodule

// File: doc/ota_cal_ctrl.md
OTA_CAL_CTRL -- requirements
Module: ota_cal_ctrl

Interface
REQ-001 SHALL have parameter CH, default 2: number of OTA trim channels, legal 1..4.
REQ-002 SHALL have parameter W, default 6: trim code width, legal 3..8.
REQ-003 SHALL have parameter SETTLE, default 3: settle cycles per SAR trial bit, legal 1..15.
REQ-004 SHALL have port clk, input, 1: single clock, all state rising-edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port ena, input, 1: when low, start and load_valid are ignored and state holds.
REQ-007 SHALL have port start, input, 1: level-sampled request to begin SAR calibration.
REQ-008 SHALL have port abort, input, 1: cancel an in-progress calibration.
REQ-009 SHALL have port ch_sel, input, 2: target channel for start and load.
REQ-010 SHALL have port load_valid, input, 1: manual trim write strobe.
REQ-011 SHALL have port load_data, input, W: manual trim value.
REQ-012 SHALL have port cmp_in, input, 1: OTA comparator result, 1 = output above reference.
REQ-013 SHALL have port trim_out, output, CH*W: channel c drives bits [c*W +: W].
REQ-014 SHALL have port busy, output, 1: high while not IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle pulse at calibration end.
REQ-016 SHALL have port err, output, 1: one-cycle pulse on rejected command.

Function
REQ-017 SHALL implement FSM states IDLE, SETTLE, SAMPLE, FINISH.
REQ-018 In IDLE with ena=1, load_valid=1 and ch_sel<CH SHALL write load_data to trim[ch_sel] at the next edge.
REQ-019 In IDLE with ena=1, start=1 and ch_sel<CH SHALL latch ch_sel, save the old code, set trial = 1<<(W-1), bit index = W-1, and enter SETTLE.
REQ-020 When start and load_valid are both high in IDLE, start SHALL win and the load SHALL be dropped.
REQ-021 ch_sel>=CH with start or load_valid in IDLE SHALL pulse err and change no state.
REQ-022 start or load_valid while busy SHALL be ignored; no err.
REQ-023 SETTLE SHALL last exactly SETTLE cycles, then SAMPLE for exactly 1 cycle.
REQ-024 In SAMPLE, sampled comparator=1 SHALL clear the current trial bit; a sampled value of 0 SHALL keep it. Then, if bit index>0, set the next lower bit and return to SETTLE; otherwise go to FINISH.
REQ-025 Total calibration SHALL take W*(SETTLE+1) cycles from start acceptance to entering FINISH.
REQ-026 FINISH SHALL last 1 cycle with done=1, commit trial to trim[ch], then enter IDLE.
REQ-027 During calibration, trim[selected channel] SHALL drive the live trial code; other channels SHALL hold.
REQ-028 abort=1 in SETTLE or SAMPLE SHALL restore the saved code, enter IDLE next edge, and produce no done pulse.
REQ-029 abort in FINISH SHALL be ignored; the result commits.
REQ-030 All arithmetic SHALL be unsigned W-bit; no wrap is possible, and the result range SHALL be 0..2^W-1.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, every trim channel = 1<<(W-1) (mid-scale), and busy=done=err=0.
REQ-032 Reset during calibration SHALL discard the trial; the saved code SHALL NOT be restored.
REQ-033 Outputs SHALL be stable from the first edge after rst_n deasserts.

Configuration
REQ-034 Macro OTA_CAL_CMP_SYNC_EN defined SHALL insert a 2-flop synchronizer (reset to 0) on cmp_in; SAMPLE SHALL use the synchronizer output.
REQ-035 Macro OTA_CAL_CMP_SYNC_EN undefined SHALL make SAMPLE use cmp_in directly.
REQ-036 Cycle counts SHALL be identical in both builds; the user guarantees SETTLE>=2 when the synchronizer is compiled in.

Verification
REQ-037 Reset: CH=2, W=6 -> trim_out=12'h820, busy=0 -> after 1 clk with no stimulus, values are unchanged.
REQ-038 SAR: CH=2, W=6, SETTLE=3, ch_sel=1, model cmp_in = (trial>37) -> busy for 24 cycles, done pulse, trim_out[11:6]=6'd37, trim_out[5:0]=6'd32.
REQ-039 Abort: same setup, manual load ch1=6'd10 first, abort at cycle 9 of calibration -> trim_out[11:6]=6'd10, no done pulse.
REQ-040 Bounds: cmp_in stuck 1 -> result 0; cmp_in stuck 0 -> result 63; both finish in 24 cycles.
REQ-041 Errors: ch_sel=2 with CH=2 and start=1 -> err pulse, busy=0; load_valid during busy -> trims unchanged, no err.
REQ-042 Reset at cycle 12 of calibration -> all channels =6'd32 immediately, FSM in IDLE.
